// File: rtl/kernel_line_fanout_if.sv
// Handshake bundle between the raster feeder, the line fanout and the kernel crossbar.
// The slave modport is the fanout block itself; the master modport is its surroundings.
interface kernel_line_fanout_if #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 18
) ();
    logic                              s_axis_tvalid;
    logic [DATA_WIDTH-1:0]             s_axis_tdata;
    logic                              s_axis_tuser;
    logic                              s_axis_tready;
    logic [KERNEL_SIZE-1:0]            m_axis_tvalid;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] m_axis_tdata;
    logic [KERNEL_SIZE-1:0]            m_axis_tready;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata
    );
endinterface

// File: rtl/kernel_line_fanout.sv
// Raster-to-column fanout: keeps KERNEL_SIZE-1 line buffers and presents the current pixel
// plus the pixels directly above it as independent per-channel streams.
module kernel_line_fanout #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 18,
    parameter int IMG_WIDTH   = 64,
    parameter int COL_W       = $clog2(IMG_WIDTH)
) (
    input  logic                clk,
    input  logic                rstn,
    kernel_line_fanout_if.slave bus
);
    localparam int RF_W = (KERNEL_SIZE > 2) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [RF_W-1:0]  MAX_ROWS = RF_W'(KERNEL_SIZE - 1);

    function automatic logic [RF_W-1:0] sat_rows_inc(input logic [RF_W-1:0] rows);
        return (rows == MAX_ROWS) ? rows : rows + 1'b1;
    endfunction

    // Channels 0..rows are backed by real rows; the rest are still above the frame top.
    function automatic logic [KERNEL_SIZE-1:0] fill_mask(input logic [RF_W-1:0] rows);
        logic [KERNEL_SIZE-1:0] m;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            m[i] = (i <= int'(rows));
        end
        return m;
    endfunction

    logic [COL_W-1:0]                  col;
    logic [RF_W-1:0]                   rows_filled;
    logic [KERNEL_SIZE-1:0]            vld_p1;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] data_p1;

    logic                              accept_p0;
    logic [COL_W-1:0]                  col_p0;
    logic [RF_W-1:0]                   rows_p0;
    logic [DATA_WIDTH-1:0]             line_rd_p0 [KERNEL_SIZE-1];
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] data_p0;

    // Stage p0: accept decision, effective raster position, line-buffer read/shift.
    assign bus.s_axis_tready = rstn && (&(~vld_p1 | bus.m_axis_tready));
    assign accept_p0         = bus.s_axis_tvalid && bus.s_axis_tready;

    always_comb begin
        col_p0  = bus.s_axis_tuser ? '0 : col;
        rows_p0 = bus.s_axis_tuser ? '0 : rows_filled;
    end

    for (genvar g = 0; g < KERNEL_SIZE - 1; g++) begin : g_line
        logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];
        logic [DATA_WIDTH-1:0] wr_data;

        if (g == 0) begin : g_head
            assign wr_data = bus.s_axis_tdata;
        end else begin : g_tail
            assign wr_data = line_rd_p0[g-1];
        end

        assign line_rd_p0[g] = mem[col_p0];

        always_ff @(posedge clk) begin
            if (accept_p0) begin
                mem[col_p0] <= wr_data;
            end
        end
    end

    always_comb begin
        data_p0 = '0;
        data_p0[0 +: DATA_WIDTH] = bus.s_axis_tdata;
        for (int i = 1; i < KERNEL_SIZE; i++) begin
            data_p0[i*DATA_WIDTH +: DATA_WIDTH] = line_rd_p0[i-1];
        end
    end

    // Stage p1: registered column window and per-channel pending mask.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col         <= '0;
            rows_filled <= '0;
            vld_p1      <= '0;
            data_p1     <= '0;
        end else if (accept_p0) begin
            vld_p1  <= fill_mask(rows_p0);
            data_p1 <= data_p0;
            if (col_p0 == LAST_COL) begin
                col         <= '0;
                rows_filled <= sat_rows_inc(rows_p0);
            end else begin
                col         <= col_p0 + 1'b1;
                rows_filled <= rows_p0;
            end
        end else begin
            vld_p1 <= vld_p1 & ~bus.m_axis_tready;
        end
    end

    assign bus.m_axis_tvalid = vld_p1;
    assign bus.m_axis_tdata  = data_p1;
endmodule

// File: tb/tb_kernel_line_fanout.sv
// Directed vector bench for kernel_line_fanout with a 4-pixel row and a 3-row window.
module tb_kernel_line_fanout;
    localparam int KS = 3;
    localparam int DW = 18;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    kernel_line_fanout_if #(.KERNEL_SIZE(KS), .DATA_WIDTH(DW)) bus ();

    kernel_line_fanout #(
        .KERNEL_SIZE(KS),
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IW)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    typedef struct {
        logic             rst_n;
        logic             vld;
        logic             usr;
        logic [DW-1:0]    d;
        logic [KS-1:0]    rdy;
        logic             srdy;
        logic [KS-1:0]    mvld;
        logic [KS-1:0]    dm;
        logic [KS*DW-1:0] e;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic r, input logic v, input logic u, input int d,
                                input logic [KS-1:0] rdy, input logic srdy,
                                input logic [KS-1:0] mvld, input logic [KS-1:0] dm,
                                input int e0, input int e1, input int e2);
        vec_t t;
        t.rst_n = r;
        t.vld   = v;
        t.usr   = u;
        t.d     = DW'(d);
        t.rdy   = rdy;
        t.srdy  = srdy;
        t.mvld  = mvld;
        t.dm    = dm;
        t.e     = {DW'(e2), DW'(e1), DW'(e0)};
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        rstn              = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tuser  = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = '1;

        // Frame rows 0..2 and the first pixel of row 3 (saturation).
        vecs.push_back(mk(1, 1, 1, 1, 3'b111, 1, 3'b001, 3'b001, 1, 0, 0));
        for (int p = 2; p <= 4; p++)   vecs.push_back(mk(1, 1, 0, p, 3'b111, 1, 3'b001, 3'b001, p, 0, 0));
        for (int p = 5; p <= 8; p++)   vecs.push_back(mk(1, 1, 0, p, 3'b111, 1, 3'b011, 3'b011, p, p - 4, 0));
        for (int p = 9; p <= 13; p++)  vecs.push_back(mk(1, 1, 0, p, 3'b111, 1, 3'b111, 3'b111, p, p - 4, p - 8));
        // Channel 1 stalls while 0 and 2 drain; offered pixel 14 must wait.
        for (int k = 0; k < 3; k++)    vecs.push_back(mk(1, 1, 0, 14, 3'b101, 0, 3'b010, 3'b111, 13, 9, 5));
        vecs.push_back(mk(1, 1, 0, 14, 3'b111, 1, 3'b111, 3'b111, 14, 10, 6));
        // Mid-row restart at col 2, then a fresh frame builds up again.
        vecs.push_back(mk(1, 1, 1, 77, 3'b111, 1, 3'b001, 3'b001, 77, 0, 0));
        for (int p = 78; p <= 80; p++) vecs.push_back(mk(1, 1, 0, p, 3'b111, 1, 3'b001, 3'b001, p, 0, 0));
        for (int p = 81; p <= 84; p++) vecs.push_back(mk(1, 1, 0, p, 3'b111, 1, 3'b011, 3'b011, p, p - 4, 0));
        vecs.push_back(mk(1, 1, 0, 85, 3'b111, 1, 3'b111, 3'b111, 85, 81, 77));
        // Reset while all three channels are pending and nobody drains.
        vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 3'b000, 3'b111, 0, 0, 0));
        for (int p = 90; p <= 93; p++) vecs.push_back(mk(1, 1, 0, p, 3'b111, 1, 3'b001, 3'b001, p, 0, 0));
        vecs.push_back(mk(1, 1, 0, 94, 3'b111, 1, 3'b011, 3'b011, 94, 90, 0));

        repeat (3) @(posedge clk);
        #1;
        check("reset_m_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
        check("reset_m_tdata", 64'(bus.m_axis_tdata), 64'(0));
        check("reset_s_tready", 64'(bus.s_axis_tready), 64'(0));

        foreach (vecs[k]) begin
            @(negedge clk);
            rstn              = vecs[k].rst_n;
            bus.s_axis_tvalid = vecs[k].vld;
            bus.s_axis_tuser  = vecs[k].usr;
            bus.s_axis_tdata  = vecs[k].d;
            bus.m_axis_tready = vecs[k].rdy;
            #1;
            check($sformatf("v%0d_s_tready", k), 64'(bus.s_axis_tready), 64'(vecs[k].srdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_m_tvalid", k), 64'(bus.m_axis_tvalid), 64'(vecs[k].mvld));
            for (int i = 0; i < KS; i++) begin
                if (vecs[k].dm[i]) begin
                    check($sformatf("v%0d_ch%0d_data", k, i),
                          64'(bus.m_axis_tdata[i*DW +: DW]), 64'(vecs[k].e[i*DW +: DW]));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kernel_line_fanout.md
Name: kernel_line_fanout

Overview:
- Upstream feeder for the kernel crossbar in the map-inflation pipeline.
- Accepts a single raster stream of occupancy-cost pixels and keeps KERNEL_SIZE-1 line buffers.
- Emits KERNEL_SIZE vertically aligned pixels (same column; current row and the rows above) as parallel per-channel AXI-Stream lanes.
- Each channel carries its own valid, so rows that do not exist yet at frame top are presented as empty channels.

Parameters:
- KERNEL_SIZE, 3, number of output channels (vertical window height).
- DATA_WIDTH, 18, pixel/cost width in bits.
- IMG_WIDTH, 64, pixels per raster row (line-buffer depth).
- COL_W, $clog2(IMG_WIDTH), column counter width (derived).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tuser  in  1  start-of-frame; marks the first pixel of a frame.
- s_axis_tready  out  1  input accept.
- m_axis_tvalid  out  KERNEL_SIZE  per-channel valid; bit i = pixel i rows above current.
- m_axis_tdata  out  DATA_WIDTH*KERNEL_SIZE  packed; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tready  in  KERNEL_SIZE  per-channel ready from the crossbar.

Behaviour:
- Reset: rstn is synchronous, active-low; clk is the clock.
  - While rstn=0: m_axis_tvalid=0, m_axis_tdata=0, col=0, rows_filled=0, pending=0, s_axis_tready=0.
  - Line-buffer contents are not reset; they are never exposed without a valid bit.
- Pending mask: pending[KERNEL_SIZE-1:0] is a register and drives m_axis_tvalid directly.
  - Bit i clears on a cycle where pending[i] && m_axis_tready[i].
  - Channels drain independently and in any order.
- Input ready: s_axis_tready = rstn && &(~pending | m_axis_tready). It is combinational, so a new pixel is accepted in the same cycle the last pending channel drains.
- Accept: s_axis_tvalid && s_axis_tready.
- Effective position on accept:
  - If s_axis_tuser=1: use col=0 and rows_filled=0, regardless of the current counters (mid-frame restart).
  - Otherwise use the current col and rows_filled.
- Outputs registered on accept (latency 1 cycle from accept to m_axis_tvalid):
  - Channel 0 data = s_axis_tdata.
  - Channel i>0 data = line[i-1][col].
  - pending bit i = (i <= rows_filled), so the mask is contiguous from bit 0.
- Line shift on accept, same column: line[0][col] <= s_axis_tdata; line[i][col] <= line[i-1][col] for i = 1..KERNEL_SIZE-2.
- Column wrap:
  - col increments on accept and wraps from IMG_WIDTH-1 to 0.
  - On wrap, rows_filled increments, saturating at KERNEL_SIZE-1.
- No accept: all counters, line contents and output data hold. m_axis_tdata is stable while any pending bit is set.
- All-channels-accept with pending=0: s_axis_tready=1 (idle state).
- Reset mid-operation: pending is discarded, counters are cleared, and the next pixel is treated as row 0 even without tuser.
- Memory: line buffers are plain arrays with one read and one write per column per cycle, inferrable as distributed/block RAM.

Test Plan:
- (IMG_WIDTH=4, KERNEL_SIZE=3, all m_axis_tready=1.)
- Stream pixels 1..4 with tuser on pixel 1.
  -> Four outputs, each m_axis_tvalid=001, ch0 = 1,2,3,4; s_axis_tready stays 1.
- Continue with pixels 5..8.
  -> m_axis_tvalid=011; col0 gives ch0=5, ch1=1; col3 gives ch0=8, ch1=4.
- Continue with pixels 9..12, then 13.
  -> 9 gives mask 111 with ch0=9, ch1=5, ch2=1.
  -> 13 gives mask 111 with ch0=13, ch1=9, ch2=5 (saturation; oldest row dropped).
- With pending=111, hold m_axis_tready=101 for 3 cycles.
  -> pending becomes 010 after 1 cycle; s_axis_tready=0 and data frozen.
  -> Raise ready[1]: pending clears and s_axis_tready=1 in that same cycle.
- Mid-row (col=2), send a pixel with tuser=1 and value 77.
  -> Output mask 001, ch0=77; the next pixel lands at col1 with mask 001.
- Deassert rstn for 1 cycle while pending=111.
  -> Next cycle m_axis_tvalid=000 and s_axis_tready=0 during reset.
  -> After release, the next pixel gives mask 001.
